// File: rtl/rx_frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_buffer_pkg
//  Description : Shared definitions for the receive frame buffer: write-side
//                state encoding and default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package rx_frame_buffer_pkg;

    // Default geometry of the buffer
    localparam int c_DEF_DATA_W = 64;
    localparam int c_DEF_ADDR_W = 9;

    // Write-side frame state
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_DROP     = 2'd2,
        ST_WAIT_CRC = 2'd3
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/rx_frame_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_buffer_ram
//  Description : Simple dual-port RAM, one write port and one registered read
//                port. The read register doubles as the client output word.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_buffer_ram #(
    parameter int WIDTH  = 73,
    parameter int ADDR_W = 9
) (
    input  logic              rxclk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [WIDTH-1:0] r_rd_data;

    // Storage array write; contents are not reset
    always_ff @(posedge rxclk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; holds its value until the next read enable
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/rx_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_buffer
//  Description : Store-and-forward receive frame buffer. Frames are written as
//                pending, committed on a good CRC verdict, rewound on a bad
//                verdict, overflow or missing verdict. Only committed words are
//                presented to the client, with backpressure and an EOF marker.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_buffer
    import rx_frame_buffer_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int CTRL_W = DATA_W / 8,
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  logic              rxclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rxd,
    input  logic [CTRL_W-1:0] rxc,
    input  logic              receiving_frame,
    input  logic              crc_valid,
    input  logic              crc_ok,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic [CTRL_W-1:0] rx_data_valid,
    output logic              rx_eof,
    output logic              frame_good,
    output logic              frame_dropped,
    output logic [ADDR_W:0]   fifo_level
);

    localparam int              c_ENTRY_W = DATA_W + CTRL_W + 1;
    localparam logic [ADDR_W:0] c_DEPTH   = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] c_PTR_ONE = (ADDR_W+1)'(1);

    // Input stage
    logic [DATA_W-1:0] r_rxd_d1;
    logic [CTRL_W-1:0] r_rxc_d1;
    logic              r_rf_d1;

    // Write side
    wr_state_t         r_state;
    logic              r_drop;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_commit_ptr;
    logic              r_frame_good;
    logic              r_frame_dropped;

    // Read side
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_out_vld;
    logic [ADDR_W:0]   r_level;

    logic              w_in_wait;
    logic              w_commit;
    logic              w_rewind;
    logic [ADDR_W:0]   w_base_ptr;
    logic              w_full;
    logic              w_wr_en;
    logic              w_eof;
    logic [c_ENTRY_W-1:0] w_wr_data;
    logic              w_fire;
    logic [c_ENTRY_W-1:0] w_rd_entry;

    // The verdict is resolved before any new-frame word is placed, so the
    // write address is taken from the post-verdict pointer (w_base_ptr).
    assign w_in_wait  = (r_state == ST_WAIT_CRC);
    assign w_commit   = w_in_wait & crc_valid & crc_ok & ~r_drop;
    assign w_rewind   = w_in_wait & ~w_commit & (crc_valid | r_rf_d1);
    assign w_base_ptr = w_rewind ? r_commit_ptr : r_wr_ptr;
    assign w_full     = ((w_base_ptr - r_rd_ptr) == c_DEPTH);
    assign w_wr_en    = r_rf_d1 & (r_state != ST_DROP) & ~w_full;
    assign w_eof      = r_rf_d1 & ~receiving_frame;
    assign w_wr_data  = {w_eof, r_rxc_d1, r_rxd_d1};

    // Only committed words are read, so reads never collide with writes.
    assign w_fire     = (r_rd_ptr != r_commit_ptr) & (~r_out_vld | rx_ready);

    // Register the incoming word, its mask and the frame flag once
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_rxd_d1 <= '0;
            r_rxc_d1 <= '0;
            r_rf_d1  <= 1'b0;
        end else begin
            r_rxd_d1 <= rxd;
            r_rxc_d1 <= rxc;
            r_rf_d1  <= receiving_frame;
        end
    end

    // Write FSM: frame capture, commit / rewind and status pulses
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_drop          <= 1'b0;
            r_wr_ptr        <= '0;
            r_commit_ptr    <= '0;
            r_frame_good    <= 1'b0;
            r_frame_dropped <= 1'b0;
        end else begin
            r_frame_good    <= w_commit;
            r_frame_dropped <= w_rewind;
            if (w_commit) begin
                r_commit_ptr <= r_wr_ptr;
            end
            if (w_wr_en) begin
                r_wr_ptr <= w_base_ptr + c_PTR_ONE;
            end else if (w_rewind) begin
                r_wr_ptr <= r_commit_ptr;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_rf_d1) begin
                        r_state <= w_full ? ST_DROP : ST_WRITE;
                        r_drop  <= w_full;
                    end
                end
                ST_WRITE: begin
                    if (!r_rf_d1) begin
                        r_state <= ST_WAIT_CRC;
                    end else if (w_full) begin
                        r_state <= ST_DROP;
                        r_drop  <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (!r_rf_d1) begin
                        r_state <= ST_WAIT_CRC;
                    end
                end
                ST_WAIT_CRC: begin
                    if (r_rf_d1) begin
                        r_state <= w_full ? ST_DROP : ST_WRITE;
                        r_drop  <= w_full;
                    end else if (crc_valid) begin
                        r_state <= ST_IDLE;
                        r_drop  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read pointer and output-valid flag with client backpressure
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_rd_ptr  <= '0;
            r_out_vld <= 1'b0;
        end else begin
            if (w_fire) begin
                r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
                r_out_vld <= 1'b1;
            end else if (rx_ready) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    // Occupancy counts committed plus pending words
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
        end else begin
            r_level <= r_wr_ptr - r_rd_ptr;
        end
    end

    rx_frame_buffer_ram #(
        .WIDTH  (c_ENTRY_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .rxclk     (rxclk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_base_ptr[ADDR_W-1:0]),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_fire),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_entry)
    );

    assign rx_data       = w_rd_entry[DATA_W-1:0];
    assign rx_data_valid = r_out_vld ? w_rd_entry[DATA_W +: CTRL_W] : '0;
    assign rx_eof        = r_out_vld & w_rd_entry[c_ENTRY_W-1];
    assign frame_good    = r_frame_good;
    assign frame_dropped = r_frame_dropped;
    assign fifo_level    = r_level;

endmodule
`default_nettype wire
